// File: rtl/wb_dma_copy.sv
// Pipelined Wishbone initiator that copies len 64-bit words from src to dst, one read then one write at a time.
// States: IDLE wait cmd | RD_REQ/RD_WAIT read | WR_REQ/WR_WAIT write | GAP bus idle between words | DONE end pulse.
module wb_dma_copy #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LEN_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [63:0]      i_src,
  input  logic [63:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic             o_aborted,
  output logic [LEN_W-1:0] o_remaining,
  output logic [63:0]      o_wb_adr,
  output logic [63:0]      o_wb_dat,
  input  logic [63:0]      i_wb_dat,
  output logic             o_wb_we,
  output logic [7:0]       o_wb_sel,
  output logic             o_wb_stb,
  output logic             o_wb_cyc,
  input  logic             i_wb_ack,
  input  logic             i_wb_stall
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_GAP, S_DONE
  } state_t;

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [63:0]      src_q, src_d, dst_q, dst_d, dat_q, dat_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d, abt_q, abt_d;
  logic             busy, in_rd, in_wr, is_req, ack_now, expired;

  assign in_rd   = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
  assign in_wr   = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
  assign is_req  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  // An ack during a stalled request cycle does not belong to this request.
  assign ack_now = i_wb_ack && !(is_req && i_wb_stall);
  assign expired = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    abt_d   = abt_q;
    if (busy && i_abort) abt_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          src_d   = i_src & ~64'h7;
          dst_d   = i_dst & ~64'h7;
          rem_d   = i_len;
          err_d   = 1'b0;
          abt_d   = 1'b0;
          tmr_d   = TMR_LOAD;
          state_d = (i_len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ, S_RD_WAIT: begin
        if (ack_now) begin
          dat_d   = i_wb_dat;
          tmr_d   = TMR_LOAD;
          state_d = S_WR_REQ;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
          if (state_q == S_RD_REQ && !i_wb_stall) state_d = S_RD_WAIT;
        end
      end
      S_WR_REQ, S_WR_WAIT: begin
        if (ack_now) begin
          src_d   = src_q + 64'd8;
          dst_d   = dst_q + 64'd8;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_GAP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
          if (state_q == S_WR_REQ && !i_wb_stall) state_d = S_WR_WAIT;
        end
      end
      S_GAP: begin
        tmr_d   = TMR_LOAD;
        state_d = (abt_q || i_abort) ? S_DONE : S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      dat_q   <= '0;
      rem_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
    end
  end

  assign o_busy      = busy;
  assign o_done      = (state_q == S_DONE);
  assign o_error     = err_q;
  assign o_aborted   = abt_q;
  assign o_remaining = rem_q;
  assign o_wb_cyc    = in_rd || in_wr;
  assign o_wb_stb    = is_req;
  assign o_wb_we     = in_wr;
  assign o_wb_sel    = is_req ? 8'hFF : 8'h00;
  assign o_wb_adr    = in_wr ? dst_q : (in_rd ? src_q : 64'h0);
  assign o_wb_dat    = dat_q;

endmodule
